// File: rtl/jk_seq_ctrl_pkg.sv
// Shared types for the JK sequencing controller: command op codes and FSM states.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_UP     = 2'b01,
    OP_DOWN   = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/jk_seq_ctrl_if.sv
// Command handshake between the host sequencer (master) and the controller (slave).
interface jk_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_len;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_seq_ctrl_cell.sv
// Single JK flip-flop cell. No reset of its own: the controller clears it via J/K.
module jk_cell (
  input  logic clk,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);
  // standard JK behaviour: hold / reset / set / toggle
  always_ff @(posedge clk) begin
    unique case ({j, k})
      2'b01:   q <= 1'b0;
      2'b10:   q <= 1'b1;
      2'b11:   q <= ~q;
      default: q <= q;
    endcase
  end

  assign q_bar = ~q;
endmodule

// File: rtl/jk_seq_ctrl.sv
// Sequencing controller driving a bank of WIDTH JK cells as a loadable
// up/down counter or masked toggler, one command at a time.
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  jk_seq_ctrl_if.slave     cmd,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t           state;
  op_t              op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] up_t, dn_t;
  logic             accept;

  // Ready is a decode of IDLE, forced low while reset is asserted so the
  // first rst=0 cycle already shows ready.
  assign cmd.cmd_ready = (state == S_IDLE) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // Cell bank
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i]),
      .q_bar (qb[i])
    );
  end

  // Ripple-carry style toggle enables: a bit flips when all lower bits are
  // ones (counting up) or all zeros (counting down).
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q[i-1];
      dn_t[i] = dn_t[i-1] & qb[i-1];
    end
  end

  // Excitation: reset clears the cells, RUN applies the latched op, else hold
  always_comb begin
    j = '0;
    k = '0;
    if (rst) begin
      k = '1;
    end else if (state == S_RUN) begin
      unique case (op_r)
        OP_LOAD:   begin j = data_r; k = ~data_r; end
        OP_UP:     begin j = up_t;   k = up_t;    end
        OP_DOWN:   begin j = dn_t;   k = dn_t;    end
        OP_TOGGLE: begin j = data_r; k = data_r;  end
        default:   begin j = '0;     k = '0;      end
      endcase
    end
  end

  // Controller FSM with command latch, step counter and registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_r   <= OP_LOAD;
      data_r <= '0;
      rem    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      // wrap flags the edge that rolls the counter over in either direction
      wrap <= (state == S_RUN) &&
              (((op_r == OP_UP) && (&q)) || ((op_r == OP_DOWN) && !(|q)));
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            op_r   <= op_t'(cmd.cmd_op);
            data_r <= cmd.cmd_data;
            if (op_t'(cmd.cmd_op) == OP_LOAD) begin
              rem   <= CNT_W'(1);
              state <= S_RUN;
              busy  <= 1'b1;
            end else if (cmd.cmd_len == '0) begin
              rem   <= '0;
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              rem   <= cmd.cmd_len;
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (rem != '0) rem <= rem - 1'b1;
          if (rem == CNT_W'(1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed bench for jk_seq_ctrl, WIDTH=4: reset, load, up/down with wrap,
// toggle, abort by reset and zero-length command.
module tb_jk_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] q, j, k;
  logic             busy, done, wrap;

  int nvec = 0;
  int nerr = 0;

  jk_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cif ();

  jk_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (cif.slave),
    .q    (q),
    .j    (j),
    .k    (k),
    .busy (busy),
    .done (done),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock edge, then settle at the following negedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = data;
    cif.cmd_len   = len;
    step();
    cif.cmd_valid = 1'b0;
  endtask

  // LOAD then wait out RUN and DONE so the controller is idle again
  task automatic preload(input logic [3:0] v);
    issue(2'b00, v, 8'd0);
    step();
    step();
    chk("preload_q", 32'(q), 32'(v));
  endtask

  initial begin
    rst = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_data  = '0;
    cif.cmd_len   = '0;

    // reset
    #1;
    chk("rst_ready_pre", 32'(cif.cmd_ready), 32'h0);
    chk("rst_j", 32'(j), 32'h0);
    chk("rst_k", 32'(k), 32'hF);
    @(negedge clk);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_ready", 32'(cif.cmd_ready), 32'h0);
    step();
    chk("rst_q2", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_ready_after", 32'(cif.cmd_ready), 32'h1);
    chk("idle_j", 32'(j), 32'h0);
    chk("idle_k", 32'(k), 32'h0);

    // LOAD 1010
    issue(2'b00, 4'b1010, 8'd0);
    chk("ld_busy", 32'(busy), 32'h1);
    chk("ld_j", 32'(j), 32'hA);
    chk("ld_k", 32'(k), 32'h5);
    chk("ld_ready_run", 32'(cif.cmd_ready), 32'h0);
    step();
    chk("ld_q", 32'(q), 32'hA);
    chk("ld_done", 32'(done), 32'h1);
    chk("ld_ready_done", 32'(cif.cmd_ready), 32'h0);
    chk("ld_jdone", 32'(j), 32'h0);
    step();
    chk("ld_done_end", 32'(done), 32'h0);
    chk("ld_ready_back", 32'(cif.cmd_ready), 32'h1);

    // UP len 3 from 1110
    preload(4'b1110);
    issue(2'b01, 4'b0000, 8'd3);
    chk("up_j0", 32'(j), 32'h1);
    step();
    chk("up_q1", 32'(q), 32'hF);
    chk("up_w1", 32'(wrap), 32'h0);
    chk("up_j1", 32'(j), 32'hF);
    step();
    chk("up_q2", 32'(q), 32'h0);
    chk("up_w2", 32'(wrap), 32'h1);
    chk("up_busy2", 32'(busy), 32'h1);
    step();
    chk("up_q3", 32'(q), 32'h1);
    chk("up_w3", 32'(wrap), 32'h0);
    chk("up_done", 32'(done), 32'h1);
    step();
    chk("up_ready", 32'(cif.cmd_ready), 32'h1);

    // DOWN len 2 from 0001
    preload(4'b0001);
    issue(2'b10, 4'b0000, 8'd2);
    chk("dn_j0", 32'(j), 32'h1);
    step();
    chk("dn_q1", 32'(q), 32'h0);
    chk("dn_w1", 32'(wrap), 32'h0);
    chk("dn_d1", 32'(done), 32'h0);
    chk("dn_j1", 32'(j), 32'hF);
    step();
    chk("dn_q2", 32'(q), 32'hF);
    chk("dn_w2", 32'(wrap), 32'h1);
    chk("dn_d2", 32'(done), 32'h1);
    step();
    chk("dn_wend", 32'(wrap), 32'h0);

    // TOGGLE mask 0101 len 2 from 1010
    preload(4'b1010);
    issue(2'b11, 4'b0101, 8'd2);
    chk("tg_j", 32'(j), 32'h5);
    chk("tg_k", 32'(k), 32'h5);
    step();
    chk("tg_q1", 32'(q), 32'hF);
    chk("tg_w1", 32'(wrap), 32'h0);
    step();
    chk("tg_q2", 32'(q), 32'hA);
    chk("tg_w2", 32'(wrap), 32'h0);
    chk("tg_done", 32'(done), 32'h1);
    step();

    // UP len 10 from 0000, aborted by reset after E3
    preload(4'b0000);
    issue(2'b01, 4'b0000, 8'd10);
    step();
    step();
    step();
    chk("ab_q3", 32'(q), 32'h3);
    rst = 1'b1;
    #1;
    chk("ab_j", 32'(j), 32'h0);
    chk("ab_k", 32'(k), 32'hF);
    chk("ab_ready", 32'(cif.cmd_ready), 32'h0);
    @(negedge clk);
    step();
    chk("ab_q", 32'(q), 32'h0);
    chk("ab_done", 32'(done), 32'h0);
    chk("ab_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    #1;
    chk("ab_ready_after", 32'(cif.cmd_ready), 32'h1);
    @(negedge clk);
    step();
    chk("ab_nodone", 32'(done), 32'h0);
    chk("ab_q_hold", 32'(q), 32'h0);

    // UP len 0: straight to DONE, no cell change
    issue(2'b01, 4'b0000, 8'd0);
    chk("z_done", 32'(done), 32'h1);
    chk("z_busy", 32'(busy), 32'h0);
    chk("z_q", 32'(q), 32'h0);
    chk("z_ready", 32'(cif.cmd_ready), 32'h0);
    chk("z_j", 32'(j), 32'h0);
    step();
    chk("z_done_end", 32'(done), 32'h0);
    chk("z_ready_back", 32'(cif.cmd_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
